// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch bus: request/address out, ready/data back.
interface instr_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one word at a time and holds it for the decoder.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter logic [31:0] BRANCH_PC_OFS = 32'd8
) (
  input  logic                       clk,
  input  logic                       rst,
  instr_fetch_unit_if.master         imem,
  output logic [31:0]                instruction_o,
  output logic                       instr_valid_o,
  output logic [31:0]                pc_out_o,
  input  logic                       stall_i,
  input  logic                       jump_en_i,
  input  logic [31:0]                jump_addr_i
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                perf_fetch_cnt_o,
  output logic [31:0]                perf_stall_cnt_o
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      instr_q    <= 32'h0;
      pc_out_q   <= 32'h0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    valid_d    = valid_q;
    req        = 1'b0;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        req = 1'b1;
        if (imem.ready) begin
          instr_d    = imem.rdata;
          pc_out_d   = fetch_pc_q;
          valid_d    = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = StHold;
        end
      end
      StHold: begin
        // Branch decision is only honoured on the edge the held word is consumed.
        if (!stall_i) begin
          valid_d = 1'b0;
          state_d = StReq;
          if (jump_en_i) begin
            fetch_pc_d = pc_out_q + BRANCH_PC_OFS + (jump_addr_i << 2);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign imem.req      = req;
  assign imem.addr     = {fetch_pc_q[31:2], 2'b00};
  assign instruction_o = instr_q;
  assign instr_valid_o = valid_q;
  assign pc_out_o      = pc_out_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      if (state_q == StReq && imem.ready) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (valid_q && stall_i) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a rule-level reference model and a second
// instance reset at the top of the address space.
module tb_instr_fetch_unit;

  localparam logic [31:0] Key = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        ready_force = 1'b0;
  int unsigned wait_need = 0;
  int unsigned wait_ctr = 0;
  logic        chk_en = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  instr_fetch_unit_if imem0 ();
  instr_fetch_unit_if imem1 ();

  logic [31:0] instr0, pc0, instr1, pc1;
  logic        valid0, valid1;
  logic [31:0] pfc0, psc0, pfc1, psc1;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (imem0),
    .instruction_o (instr0),
    .instr_valid_o (valid0),
    .pc_out_o      (pc0),
    .stall_i       (stall),
    .jump_en_i     (jump_en),
    .jump_addr_i   (jump_addr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt_o (pfc0),
    .perf_stall_cnt_o (psc0)
`endif
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_top (
    .clk           (clk),
    .rst           (rst),
    .imem          (imem1),
    .instruction_o (instr1),
    .instr_valid_o (valid1),
    .pc_out_o      (pc1),
    .stall_i       (1'b0),
    .jump_en_i     (1'b0),
    .jump_addr_i   (32'h0)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt_o (pfc1),
    .perf_stall_cnt_o (psc1)
`endif
  );

`ifndef FETCH_PERF_CNT_EN
  assign pfc0 = 32'h0;
  assign psc0 = 32'h0;
  assign pfc1 = 32'h0;
  assign psc1 = 32'h0;
`endif

  always #5 clk = ~clk;

  // Reference model: what the fetch stage must be holding/requesting, in spec terms.
  logic        m_quiet = 1'b1;
  logic        m_held  = 1'b0;
  logic [31:0] m_fpc   = 32'h0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_pcout = 32'h0;
  logic [31:0] m_fcnt  = 32'h0;
  logic [31:0] m_scnt  = 32'h0;
  logic        m_req;

  assign m_req = !m_quiet && !m_held;

  // Memory driven from the model so stimulus never depends on DUT outputs.
  assign imem0.ready = (m_req && (wait_ctr >= wait_need)) || ready_force;
  assign imem0.rdata = m_fpc ^ Key;
  assign imem1.ready = 1'b1;
  assign imem1.rdata = imem1.addr ^ Key;

  always @(posedge clk) begin
    if (rst) begin
      m_quiet <= 1'b1;
      m_held  <= 1'b0;
      m_fpc   <= 32'h0;
      m_instr <= 32'h0;
      m_pcout <= 32'h0;
      m_fcnt  <= 32'h0;
      m_scnt  <= 32'h0;
      wait_ctr <= 0;
    end else begin
      wait_ctr <= (m_req && !imem0.ready) ? wait_ctr + 1 : 0;
      if (m_quiet) begin
        m_quiet <= 1'b0;
      end else if (!m_held) begin
        if (imem0.ready) begin
          m_held  <= 1'b1;
          m_instr <= m_fpc ^ Key;
          m_pcout <= m_fpc;
          m_fpc   <= m_fpc + 32'd4;
          m_fcnt  <= m_fcnt + 32'd1;
        end
      end else if (stall) begin
        m_scnt <= m_scnt + 32'd1;
      end else begin
        m_held <= 1'b0;
        if (jump_en) m_fpc <= m_pcout + 32'd8 + jump_addr * 32'd4;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_req", {31'h0, imem0.req}, {31'h0, m_req});
      chk("model_addr", imem0.addr, m_fpc);
      chk("model_valid", {31'h0, valid0}, {31'h0, m_held});
      chk("model_instr", instr0, m_instr);
      chk("model_pc_out", pc0, m_pcout);
`ifdef FETCH_PERF_CNT_EN
      chk("model_perf_fetch", pfc0, m_fcnt);
      chk("model_perf_stall", psc0, m_scnt);
`endif
    end
  end

  initial begin
    @(posedge clk);
    #2 chk_en = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);  // quiet cycle after reset
    chk("quiet_req", {31'h0, imem0.req}, 32'h0);
    chk("reset_addr", imem0.addr, 32'h0);
    chk("reset_valid", {31'h0, valid0}, 32'h0);
    chk("reset_instr", instr0, 32'h0);
    chk("reset_pc_out", pc0, 32'h0);
    chk("top_quiet_req", {31'h0, imem1.req}, 32'h0);
    @(negedge clk);
    chk("fetch0_req", {31'h0, imem0.req}, 32'h1);
    chk("fetch0_addr", imem0.addr, 32'h0);
    chk("top_fetch_addr", imem1.addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("hold0_valid", {31'h0, valid0}, 32'h1);
    chk("hold0_pc", pc0, 32'h0);
    chk("hold0_instr", instr0, 32'hA5A5_0000);
    chk("top_hold_pc", pc1, 32'hFFFF_FFFC);
    chk("top_hold_instr", instr1, 32'h5A5A_FFFC);
    @(negedge clk);
    chk("fetch4_addr", imem0.addr, 32'h4);
    chk("top_wrap_addr", imem1.addr, 32'h0);
    chk("top_wrap_req", {31'h0, imem1.req}, 32'h1);
    @(negedge clk);
    chk("hold4_pc", pc0, 32'h4);
    chk("hold4_instr", instr0, 32'hA5A5_0004);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_pc", pc0, 32'h4);
      chk("stall_instr", instr0, 32'hA5A5_0004);
      chk("stall_req", {31'h0, imem0.req}, 32'h0);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall_5", psc0, 32'd5);
`endif
    stall = 1'b0;
    wait_need = 3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wait_req", {31'h0, imem0.req}, 32'h1);
      chk("wait_addr", imem0.addr, 32'h8);
      if (i == 2) chk("wait_instr_kept", instr0, 32'hA5A5_0004);
    end
    @(negedge clk);
    chk("hold8_pc", pc0, 32'h8);
    chk("hold8_instr", instr0, 32'hA5A5_0008);
    wait_need = 0;
    stall = 1'b1;
    jump_en = 1'b1;
    jump_addr = 32'd5;
    @(negedge clk);
    chk("stall_jump_pc", pc0, 32'h8);
    stall = 1'b0;
    jump_en = 1'b0;
    @(negedge clk);
    chk("fetchC_addr", imem0.addr, 32'hC);
    @(negedge clk);
    chk("holdC_pc", pc0, 32'hC);
    @(negedge clk);
    chk("fetch10_addr", imem0.addr, 32'h10);
    @(negedge clk);
    chk("hold10_pc", pc0, 32'h10);
    jump_en = 1'b1;
    jump_addr = 32'hFFFF_FFFE;
    @(negedge clk);
    chk("branch_back_addr", imem0.addr, 32'h10);
    jump_en = 1'b0;
    @(negedge clk);
    chk("hold10b_pc", pc0, 32'h10);
    jump_en = 1'b1;
    jump_addr = 32'd3;
    @(negedge clk);
    chk("branch_fwd_addr", imem0.addr, 32'h24);
    jump_en = 1'b0;
    @(negedge clk);
    chk("hold24_pc", pc0, 32'h24);
    jump_en = 1'b1;
    jump_addr = 32'hFFFF_FFF4;
    @(negedge clk);
    chk("branch_under_addr", imem0.addr, 32'hFFFF_FFFC);
    jump_en = 1'b0;
    @(negedge clk);
    chk("hold_top_pc", pc0, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("pc_wrap_addr", imem0.addr, 32'h0);
    @(negedge clk);
    jump_en = 1'b1;
    jump_addr = 32'hFFFF_FFFD;
    @(negedge clk);
    chk("branch_to_top_addr", imem0.addr, 32'hFFFF_FFFC);
    jump_en = 1'b0;
    @(negedge clk);
    jump_en = 1'b1;
    jump_addr = 32'd2;
    @(negedge clk);
    chk("branch_over_addr", imem0.addr, 32'hC);
    jump_en = 1'b0;
    @(negedge clk);
    stall = 1'b1;
    ready_force = 1'b1;
    @(negedge clk);
    chk("hold_ready_pc", pc0, 32'hC);
    chk("hold_ready_instr", instr0, 32'hA5A5_000C);
    ready_force = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    chk("pre_rst_addr", imem0.addr, 32'h10);
    rst = 1'b1;
    ready_force = 1'b1;
    @(negedge clk);
    chk("rst_valid", {31'h0, valid0}, 32'h0);
    chk("rst_req", {31'h0, imem0.req}, 32'h0);
    chk("rst_addr", imem0.addr, 32'h0);
    rst = 1'b0;
    ready_force = 1'b0;
    @(negedge clk);
    chk("post_rst_req", {31'h0, imem0.req}, 32'h1);
    chk("post_rst_addr", imem0.addr, 32'h0);
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
